// File: rtl/instr_sequencer.sv
// instr_sequencer: instruction issue controller.
// Instructions are queued in a small circular FIFO. One at a time is loaded into a
// held instruction register and stepped through the 4-phase cycle state
// (00 decode, 01 load A, 10 execute, 11 write/bus) that control_unit consumes.
// The next queued instruction is popped while the current one is in its last phase,
// so back-to-back instructions issue with no idle cycle.
module instr_sequencer #(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               run,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [1:0]         current_state,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   fifo_count,
    output logic [7:0]         retired
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, EXEC} fsm_t;

    fsm_t               state;
    fsm_t               state_d;
    logic [1:0]         cs_d;
    logic               busy_d;
    logic               done_d;
    logic               retire;
    logic               push;
    logic               pop;
    logic               can_issue;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [INSTR_W-1:0] mem [DEPTH];

    // in_ready looks only at the registered count and flush, never at a same-cycle pop,
    // so the producer never sees a combinational path through the FSM.
    assign in_ready  = (fifo_count < CNT_W'(DEPTH)) && !flush;
    assign push      = in_valid && in_ready;
    assign can_issue = run && (fifo_count != '0) && !flush;

    // Next-state and next-output logic for the IDLE/EXEC sequencer.
    always_comb begin
        state_d = state;
        cs_d    = current_state;
        busy_d  = busy;
        pop     = 1'b0;
        retire  = 1'b0;
        case (state)
            IDLE: begin
                if (can_issue) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                    cs_d    = 2'b00;
                    busy_d  = 1'b1;
                end
            end
            EXEC: begin
                if (current_state != 2'b11) begin
                    cs_d = current_state + 2'd1;
                end else begin
                    // Last phase: retire and either chain the next instruction or stop.
                    retire = 1'b1;
                    cs_d   = 2'b00;
                    if (can_issue) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // done is registered, so it is raised on the edge that enters phase 11.
        done_d = (state_d == EXEC) && (cs_d == 2'b11);
    end

    // State, outputs, FIFO pointers and count; reset abandons any instruction in flight.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= IDLE;
            current_state <= 2'b00;
            busy          <= 1'b0;
            done          <= 1'b0;
            retired       <= 8'd0;
            instruction   <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            fifo_count    <= '0;
        end else begin
            state         <= state_d;
            current_state <= cs_d;
            busy          <= busy_d;
            done          <= done_d;
            if (retire) begin
                retired <= retired + 8'd1;
            end
            if (pop) begin
                instruction <= mem[rd_ptr];
            end
            if (flush) begin
                // pop is already suppressed by flush and push by in_ready.
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed stimulus against a queue-based
// reference model; completed instructions are checked by a done-triggered scoreboard.
module tb_instr_sequencer;

    localparam int DEPTH   = 4;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 3;

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic               run = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic [INSTR_W-1:0] in_instr = '0;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic [1:0]         current_state;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   fifo_count;
    logic [7:0]         retired;

    instr_sequencer #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .resetn(resetn), .run(run), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .instruction(instruction), .current_state(current_state), .busy(busy),
        .done(done), .fifo_count(fifo_count), .retired(retired)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: queued instructions, phase of the held instruction
    // (-1 = nothing executing, 0..3 = cycle phase), held value and retire count.
    logic [INSTR_W-1:0] mq[$];
    int                 mphase = -1;
    logic [INSTR_W-1:0] minstr = '0;
    logic [7:0]         mretired = 8'd0;
    bit                 model_live = 1'b0;
    // Scoreboard of completions: {retired value during done, instruction}.
    logic [23:0]        sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check in_ready, advance the model, check outputs.
    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [INSTR_W-1:0] d, input logic rn, output bit acc);
        bit ready;
        bit issue;
        run = r; flush = f; in_valid = v; in_instr = d; resetn = rn;
        #1;
        ready = (mq.size() < DEPTH) && !f;
        if (model_live) check("in_ready", 32'(in_ready), 32'(ready));
        acc = v && ready && rn;
        @(posedge clock);
        if (!rn) begin
            mq.delete();
            sb.delete();
            mphase = -1;
            minstr = '0;
            mretired = 8'd0;
            model_live = 1'b1;
            acc = 1'b0;
        end else begin
            issue = r && (mq.size() > 0) && !f;
            if (mphase < 0) begin
                if (issue) begin
                    minstr = mq.pop_front();
                    mphase = 0;
                end
            end else if (mphase < 3) begin
                mphase++;
            end else begin
                mretired++;
                if (issue) begin
                    minstr = mq.pop_front();
                    mphase = 0;
                end else begin
                    mphase = -1;
                end
            end
            if (f) mq.delete();
            if (v && ready) mq.push_back(d);
            if (mphase == 3) sb.push_back({mretired, minstr});
        end
        #1;
        if (model_live) begin
            check("current_state", 32'(current_state), (mphase < 0) ? 32'd0 : 32'(mphase));
            check("busy", 32'(busy), 32'(mphase >= 0));
            check("done", 32'(done), 32'(mphase == 3));
            check("fifo_count", 32'(fifo_count), 32'(mq.size()));
            check("retired", 32'(retired), 32'(mretired));
            check("instruction", 32'(instruction), 32'(minstr));
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic r);
        bit acc;
        for (int i = 0; i < n; i++) cyc(r, 1'b0, 1'b0, '0, 1'b1, acc);
    endtask

    task automatic push_one(input logic [INSTR_W-1:0] d, input logic r);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 64) begin
            cyc(r, 1'b0, 1'b1, d, 1'b1, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got no accept expected accept for %0h", d);
        end
    endtask

    task automatic run_until_phase(input int ph, input logic r);
        int n;
        n = 0;
        while (mphase != ph && n < 32) begin
            idle(1, r);
            n++;
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clock) begin
        logic [23:0] e;
        if (model_live && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected no completion");
            end else begin
                e = sb.pop_front();
                check("done_instr", 32'(instruction), 32'(e[15:0]));
                check("done_retired", 32'(retired), 32'(e[23:16]));
                check("done_state", 32'(current_state), 32'd3);
            end
        end
    end

    initial begin
        bit acc;
        @(negedge clock);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Single instruction
        push_one(16'hA405, 1'b1);
        idle(8, 1'b1);
        check("single_retired", 32'(retired), 32'd1);

        // Back-to-back issue
        push_one(16'h0280, 1'b1);
        push_one(16'h2300, 1'b1);
        push_one(16'h8400, 1'b1);
        idle(16, 1'b1);

        // Fill while stopped, hold off the fifth, then drain through pointer wrap
        for (int i = 0; i < 4; i++) push_one(16'h1000 + 16'(i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'h1004, 1'b1, acc);
        for (int i = 4; i < 8; i++) push_one(16'h1000 + 16'(i), 1'b1);
        idle(40, 1'b1);

        // Stop in phase 01 with two queued
        for (int i = 0; i < 3; i++) push_one(16'h2000 + 16'(i), 1'b0);
        idle(1, 1'b1);
        run_until_phase(1, 1'b1);
        idle(8, 1'b0);
        check("stop_count", 32'(fifo_count), 32'd2);
        idle(12, 1'b1);

        // Flush in phase 10 with three queued and a push pending
        for (int i = 0; i < 4; i++) push_one(16'h3000 + 16'(i), 1'b0);
        idle(1, 1'b1);
        run_until_phase(2, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'h3FFF, 1'b1, acc);
        idle(8, 1'b1);

        // Reset in phase 10
        push_one(16'h4444, 1'b1);
        run_until_phase(2, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, acc);
        idle(6, 1'b1);

        // 256 retirements wrap the counter
        for (int i = 0; i < 256; i++) push_one(16'(i * 7), 1'b1);
        idle(30, 1'b1);
        check("retired_wrap", 32'(retired), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 8) != 0, ($urandom % 40) == 0, 1'($urandom % 2),
                16'($urandom), ($urandom % 500) != 0, acc);
        end
        idle(30, 1'b1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
